// File: rtl/id_ex_stage_pkg.sv
// pipe_pkg: shared types and constants for the RISC-I EX-stage front end.
//   XLEN_DEF / RA_W_DEF : default datapath / register-address widths
//   ALU_*               : 4-bit ALU control encodings
//   fwd_sel_t           : forwarding source select
package pipe_pkg;
  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_t;
endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit: combinational forwarding select for one source operand.
//   src, rf_data          : registered source register and its file read data
//   exmem_we/rd/data      : EX/MEM forwarding tap
//   memwb_we/rd/data      : MEM/WB forwarding tap
//   sel, data             : chosen source and forwarded value
// EX/MEM is younger, so it wins when both stages match. r0 is never forwarded.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] src,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exmem_we,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            memwb_we,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output fwd_sel_t        sel,
  output logic [XLEN-1:0] data
);
  logic src_nz;
  assign src_nz = (src != '0);

  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if (src_nz && exmem_we && (exmem_rd == src)) begin
      sel  = FWD_EXMEM;
      data = exmem_data;
    end else if (src_nz && memwb_we && (memwb_rd == src)) begin
      sel  = FWD_MEMWB;
      data = memwb_data;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus ALU operand-select front end.
//   ID side   : i_valid, i_rs/i_rt/i_rd, i_rs_data/i_rt_data, i_imm, i_alu_ctrl,
//               i_alu_src, i_shift, i_reg_write/i_mem_read/i_mem_write/i_mem_to_reg
//   control   : i_flush (squash incoming), i_hold (freeze)
//   forwarding: i_exmem_{reg_write,rd,result}, i_memwb_{reg_write,rd,result}
//   EX side   : o_A, o_B, o_alu_ctrl, o_store_data, o_rd, control, o_valid
//   o_stall   : load-use stall request back to IF/ID
// Optional: define ID_EX_STALL_CNT_EN to add o_stall_cnt, a wrapping count of
// taken load-use stalls.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [RA_W-1:0] i_rs,
  input  logic [RA_W-1:0] i_rt,
  input  logic [RA_W-1:0] i_rd,
  input  logic [XLEN-1:0] i_rs_data,
  input  logic [XLEN-1:0] i_rt_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic [3:0]      i_alu_ctrl,
  input  logic            i_alu_src,
  input  logic            i_shift,
  input  logic            i_reg_write,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic            i_mem_to_reg,
  input  logic            i_flush,
  input  logic            i_hold,
  input  logic            i_exmem_reg_write,
  input  logic [RA_W-1:0] i_exmem_rd,
  input  logic [XLEN-1:0] i_exmem_result,
  input  logic            i_memwb_reg_write,
  input  logic [RA_W-1:0] i_memwb_rd,
  input  logic [XLEN-1:0] i_memwb_result,
  output logic [XLEN-1:0] o_A,
  output logic [XLEN-1:0] o_B,
  output logic [3:0]      o_alu_ctrl,
  output logic [XLEN-1:0] o_store_data,
  output logic [RA_W-1:0] o_rd,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_mem_to_reg,
  output logic            o_valid,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]     o_stall_cnt,
`endif
  output logic            o_stall
);
  logic            valid_q, valid_d;
  logic [RA_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [XLEN-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic            alu_src_q, alu_src_d, shift_q, shift_d;
  logic            reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;

  logic            stall;
  logic            bubble;
  fwd_sel_t        rs_sel, rt_sel;
  logic [XLEN-1:0] fwd_rs, fwd_rt;

  // Conservative: rt is compared even for I-type consumers. Gated by hold and
  // flush so the request is only raised when the bubble is actually inserted.
  assign stall = valid_q & mem_read_q & (rd_q != '0) & i_valid &
                 ((i_rs == rd_q) | (i_rt == rd_q)) & ~i_hold & ~i_flush;
  assign bubble = i_flush | stall;

  always_comb begin
    valid_d      = valid_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_src_d    = alu_src_q;
    shift_d      = shift_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (bubble) begin
      // flush outranks hold; stall already excludes hold
      valid_d      = 1'b0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      alu_ctrl_d   = ALU_AND;
      alu_src_d    = 1'b0;
      shift_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!i_hold) begin
      valid_d      = i_valid;
      rs_d         = i_rs;
      rt_d         = i_rt;
      rd_d         = i_rd;
      rs_data_d    = i_rs_data;
      rt_data_d    = i_rt_data;
      imm_d        = i_imm;
      alu_ctrl_d   = i_alu_ctrl;
      alu_src_d    = i_alu_src;
      shift_d      = i_shift;
      reg_write_d  = i_reg_write;
      mem_read_d   = i_mem_read;
      mem_write_d  = i_mem_write;
      mem_to_reg_d = i_mem_to_reg;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      shift_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_src_q    <= alu_src_d;
      shift_q      <= shift_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs (
    .src(rs_q), .rf_data(rs_data_q),
    .exmem_we(i_exmem_reg_write), .exmem_rd(i_exmem_rd), .exmem_data(i_exmem_result),
    .memwb_we(i_memwb_reg_write), .memwb_rd(i_memwb_rd), .memwb_data(i_memwb_result),
    .sel(rs_sel), .data(fwd_rs)
  );

  fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rt (
    .src(rt_q), .rf_data(rt_data_q),
    .exmem_we(i_exmem_reg_write), .exmem_rd(i_exmem_rd), .exmem_data(i_exmem_result),
    .memwb_we(i_memwb_reg_write), .memwb_rd(i_memwb_rd), .memwb_data(i_memwb_result),
    .sel(rt_sel), .data(fwd_rt)
  );

  // Selects are only needed for debug visibility; the value path is used here.
  logic unused_sel;
  assign unused_sel = ^{rs_sel, rt_sel};

  // Shifts operate on rt; the ALU takes shamt from B[10:6] of the immediate.
  assign o_A          = shift_q ? fwd_rt : fwd_rs;
  assign o_B          = (shift_q | alu_src_q) ? imm_q : fwd_rt;
  assign o_store_data = fwd_rt;
  assign o_alu_ctrl   = alu_ctrl_q;
  assign o_rd         = rd_q;
  assign o_reg_write  = reg_write_q;
  assign o_mem_read   = mem_read_q;
  assign o_mem_write  = mem_write_q;
  assign o_mem_to_reg = mem_to_reg_q;
  assign o_valid      = valid_q;
  assign o_stall      = stall;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_id_ex_stage;
  logic        i_clk, i_rst_n, i_valid;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [31:0] i_rs_data, i_rt_data, i_imm;
  logic [3:0]  i_alu_ctrl;
  logic        i_alu_src, i_shift, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
  logic        i_flush, i_hold;
  logic        i_exmem_reg_write, i_memwb_reg_write;
  logic [4:0]  i_exmem_rd, i_memwb_rd;
  logic [31:0] i_exmem_result, i_memwb_result;
  logic [31:0] o_A, o_B, o_store_data;
  logic [3:0]  o_alu_ctrl;
  logic [4:0]  o_rd;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_valid, o_stall;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
    .i_alu_ctrl(i_alu_ctrl), .i_alu_src(i_alu_src), .i_shift(i_shift),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_to_reg(i_mem_to_reg), .i_flush(i_flush), .i_hold(i_hold),
    .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd(i_exmem_rd), .i_exmem_result(i_exmem_result),
    .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_rd(i_memwb_rd), .i_memwb_result(i_memwb_result),
    .o_A(o_A), .o_B(o_B), .o_alu_ctrl(o_alu_ctrl), .o_store_data(o_store_data), .o_rd(o_rd),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_valid(o_valid),
`ifdef ID_EX_STALL_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_stall(o_stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: the instruction currently sitting in EX.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  ac;
    logic        asrc, sh, rw, mr, mw, m2r;
  } m_t;
  m_t          m;
  logic [31:0] m_cnt;

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
    if (src != 0 && i_exmem_reg_write && i_exmem_rd == src) return i_exmem_result;
    if (src != 0 && i_memwb_reg_write && i_memwb_rd == src) return i_memwb_result;
    return rf;
  endfunction

  // A load in EX whose destination is read by the ID instruction must wait,
  // unless the pipe is frozen or the ID instruction is being squashed.
  function automatic logic exp_stall();
    return m.v && m.mr && m.rd != 0 && i_valid && (i_rs == m.rd || i_rt == m.rd)
           && !i_hold && !i_flush;
  endfunction

  function automatic logic [31:0] exp_A();
    return m.sh ? fwd(m.rt, m.rtd) : fwd(m.rs, m.rsd);
  endfunction

  function automatic logic [31:0] exp_B();
    return (m.sh || m.asrc) ? m.imm : fwd(m.rt, m.rtd);
  endfunction

  task automatic clear_inputs();
    i_valid = 0; i_rs = 0; i_rt = 0; i_rd = 0;
    i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_alu_ctrl = 0;
    i_alu_src = 0; i_shift = 0; i_reg_write = 0; i_mem_read = 0;
    i_mem_write = 0; i_mem_to_reg = 0; i_flush = 0; i_hold = 0;
    i_exmem_reg_write = 0; i_exmem_rd = 0; i_exmem_result = 0;
    i_memwb_reg_write = 0; i_memwb_rd = 0; i_memwb_result = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    if (!i_rst_n) begin
      m = '0; m_cnt = 0;
    end else if (i_flush) begin
      m = '0;
    end else if (i_hold) begin
      m = m;
    end else if (exp_stall()) begin
      m = '0; m_cnt = m_cnt + 1;
    end else begin
      m = '{v:i_valid, rs:i_rs, rt:i_rt, rd:i_rd, rsd:i_rs_data, rtd:i_rt_data,
            imm:i_imm, ac:i_alu_ctrl, asrc:i_alu_src, sh:i_shift, rw:i_reg_write,
            mr:i_mem_read, mw:i_mem_write, m2r:i_mem_to_reg};
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst_n = 0; m = '0; m_cnt = 0;
    #12;
    checks++;
    if ({o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_rd, o_alu_ctrl} !== '0) begin
      errors++; $display("FAIL reset_ctrl got v=%b rd=%0d ac=%b want all 0", o_valid, o_rd, o_alu_ctrl);
    end
    checks++;
    if ({o_A, o_B, o_store_data, o_stall} !== '0) begin
      errors++; $display("FAIL reset_data got A=%h B=%h st=%b want 0", o_A, o_B, o_stall);
    end
`ifdef ID_EX_STALL_CNT_EN
    checks++;
    if (o_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", o_stall_cnt); end
`endif
    @(negedge i_clk);
    i_rst_n = 1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_exmem_fwd();
    clear_inputs();
    i_valid = 1; i_rs = 3; i_rt = 4; i_rd = 6; i_rs_data = 32'h11; i_rt_data = 32'h22;
    i_alu_ctrl = 4'b0010; i_reg_write = 1;
    tick();
    clear_inputs();
    i_exmem_reg_write = 1; i_exmem_rd = 3; i_exmem_result = 32'h55;
    i_memwb_reg_write = 1; i_memwb_rd = 3; i_memwb_result = 32'h66;
    #1;
    checks++;
    if (o_A !== 32'h55) begin errors++; $display("FAIL exmem_prio_A got %h want %h", o_A, 32'h55); end
    checks++;
    if (o_B !== 32'h22) begin errors++; $display("FAIL exmem_B got %h want %h", o_B, 32'h22); end
    checks++;
    if (o_alu_ctrl !== 4'b0010) begin errors++; $display("FAIL exmem_ac got %b want 0010", o_alu_ctrl); end
    i_exmem_reg_write = 0;
    #1;
    checks++;
    if (o_A !== 32'h66) begin errors++; $display("FAIL memwb_A got %h want %h", o_A, 32'h66); end
    i_memwb_rd = 4;
    #1;
    checks++;
    if (o_A !== 32'h11 || o_store_data !== 32'h66) begin
      errors++; $display("FAIL memwb_rt got A=%h sd=%h want 11 66", o_A, o_store_data);
    end
  endtask

  task automatic test_r0_guard();
    clear_inputs();
    i_valid = 1; i_rs = 0; i_rt = 0; i_rd = 7; i_reg_write = 1;
    tick();
    clear_inputs();
    i_exmem_reg_write = 1; i_exmem_rd = 0; i_exmem_result = 32'hDEAD;
    i_memwb_reg_write = 1; i_memwb_rd = 0; i_memwb_result = 32'hBEEF;
    #1;
    checks++;
    if (o_A !== 32'h0 || o_store_data !== 32'h0) begin
      errors++; $display("FAIL r0_guard got A=%h sd=%h want 0 0", o_A, o_store_data);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    i_valid = 1; i_rs = 2; i_rd = 5; i_mem_read = 1; i_reg_write = 1; i_mem_to_reg = 1;
    i_alu_src = 1; i_alu_ctrl = 4'b0010;
    tick();
    clear_inputs();
    i_valid = 1; i_rs = 1; i_rt = 5; i_rd = 8; i_reg_write = 1; i_alu_ctrl = 4'b0010;
    #1;
    checks++;
    if (o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", o_stall); end
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_reg_write !== 1'b0) begin
      errors++; $display("FAIL lu_bubble got v=%b rw=%b want 0 0", o_valid, o_reg_write);
    end
    checks++;
    if (o_stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b want 0", o_stall); end
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_rd !== 5'd8) begin
      errors++; $display("FAIL lu_issue got v=%b rd=%0d want 1 8", o_valid, o_rd);
    end
  endtask

  task automatic test_shift();
    clear_inputs();
    i_valid = 1; i_shift = 1; i_rs = 9; i_rt = 2; i_rd = 3; i_rs_data = 32'hAAAA;
    i_rt_data = 32'h1; i_imm = 32'd4 << 6; i_alu_ctrl = 4'b1001; i_reg_write = 1;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (o_A !== 32'h1) begin errors++; $display("FAIL shift_A got %h want 1", o_A); end
    checks++;
    if (o_B[10:6] !== 5'd4) begin errors++; $display("FAIL shift_shamt got %0d want 4", o_B[10:6]); end
    checks++;
    if (o_alu_ctrl !== 4'b1001) begin errors++; $display("FAIL shift_ac got %b want 1001", o_alu_ctrl); end
  endtask

  task automatic test_flush_hold();
    clear_inputs();
    i_valid = 1; i_rd = 6; i_mem_read = 1; i_reg_write = 1;
    tick();
    clear_inputs();
    i_valid = 1; i_rs = 6; i_hold = 1;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin errors++; $display("FAIL hold_stall got %b want 0", o_stall); end
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_rd !== 5'd6 || o_mem_read !== 1'b1) begin
      errors++; $display("FAIL hold_keep got v=%b rd=%0d mr=%b want 1 6 1", o_valid, o_rd, o_mem_read);
    end
`ifdef ID_EX_STALL_CNT_EN
    checks++;
    if (o_stall_cnt !== m_cnt) begin errors++; $display("FAIL hold_cnt got %0d want %0d", o_stall_cnt, m_cnt); end
`endif
    i_flush = 1;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", o_stall); end
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_rd !== 5'd0) begin
      errors++; $display("FAIL flush_hold_bubble got v=%b rw=%b rd=%0d want 0 0 0", o_valid, o_reg_write, o_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] eA, eB, eSD;
    logic [13:0] eCtl;
    for (int n = 0; n < 400; n++) begin
      i_valid = ($urandom_range(0, 7) != 0);
      i_rs = 5'($urandom_range(0, 7)); i_rt = 5'($urandom_range(0, 7)); i_rd = 5'($urandom_range(0, 7));
      i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom;
      i_alu_ctrl = 4'($urandom); i_alu_src = 1'($urandom); i_shift = ($urandom_range(0, 3) == 0);
      i_reg_write = 1'($urandom); i_mem_read = ($urandom_range(0, 2) == 0);
      i_mem_write = 1'($urandom); i_mem_to_reg = 1'($urandom);
      i_flush = ($urandom_range(0, 7) == 0); i_hold = ($urandom_range(0, 7) == 0);
      i_exmem_reg_write = 1'($urandom); i_exmem_rd = 5'($urandom_range(0, 7)); i_exmem_result = $urandom;
      i_memwb_reg_write = 1'($urandom); i_memwb_rd = 5'($urandom_range(0, 7)); i_memwb_result = $urandom;
      #1;
      eA = exp_A(); eB = exp_B(); eSD = fwd(m.rt, m.rtd);
      eCtl = {m.v, m.rd, m.ac, m.rw, m.mr, m.mw, m.m2r};
      checks++;
      if (o_A !== eA) begin errors++; $display("FAIL rnd_A cyc %0d got %h want %h", n, o_A, eA); end
      checks++;
      if (o_B !== eB) begin errors++; $display("FAIL rnd_B cyc %0d got %h want %h", n, o_B, eB); end
      checks++;
      if (o_store_data !== eSD) begin errors++; $display("FAIL rnd_sd cyc %0d got %h want %h", n, o_store_data, eSD); end
      checks++;
      if ({o_valid, o_rd, o_alu_ctrl, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg} !== eCtl) begin
        errors++; $display("FAIL rnd_ctl cyc %0d got %h want %h", n,
          {o_valid, o_rd, o_alu_ctrl, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg}, eCtl);
      end
      checks++;
      if (o_stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", n, o_stall, exp_stall()); end
`ifdef ID_EX_STALL_CNT_EN
      checks++;
      if (o_stall_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", n, o_stall_cnt, m_cnt); end
`endif
      tick();
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    i_valid = 1; i_rs = 1; i_rt = 2; i_rd = 4; i_reg_write = 1; i_mem_read = 1;
    tick();
    clear_inputs();
    i_valid = 1; i_rt = 4;
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_stall !== 1'b1) begin
      errors++; $display("FAIL mid_pre got v=%b st=%b want 1 1", o_valid, o_stall);
    end
    #1 i_rst_n = 0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_stall !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%b rw=%b st=%b want 0 0 0", o_valid, o_reg_write, o_stall);
    end
    m = '0; m_cnt = 0;
    @(negedge i_clk);
    i_rst_n = 1;
    clear_inputs();
    @(posedge i_clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_rd !== 5'd0) begin
      errors++; $display("FAIL mid_after got v=%b rd=%0d want 0 0", o_valid, o_rd);
    end
  endtask

  initial begin
    test_reset();
    test_exmem_fwd();
    test_r0_guard();
    test_load_use();
    test_shift();
    test_flush_hold();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select front end for the pipelined RISC-I EX stage.
- Captures decoded operands and control from ID once per cycle.
- Drives the ALU operand buses and the 4-bit ALU control.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and raises a load-use stall request towards ID/IF.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  ID slot holds a real instruction.
- i_rs, i_rt, i_rd  in  RA_W each  source/destination register numbers.
- i_rs_data, i_rt_data  in  XLEN each  register-file read data.
- i_imm  in  XLEN  extended immediate; for shifts, bits [10:6] carry shamt.
- i_alu_ctrl  in  4  ALU operation code.
- i_alu_src  in  1  1 = B takes imm.
- i_shift  in  1  1 = shift op (A takes rt, B takes imm).
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1 each  control.
- i_flush  in  1  squash incoming instruction (branch/jump).
- i_hold  in  1  downstream freeze.
- i_exmem_reg_write  in  1  EX/MEM forwarding write enable.
- i_exmem_rd  in  RA_W  EX/MEM destination register.
- i_exmem_result  in  XLEN  EX/MEM forwarding value.
- i_memwb_reg_write  in  1  MEM/WB forwarding write enable.
- i_memwb_rd  in  RA_W  MEM/WB destination register.
- i_memwb_result  in  XLEN  MEM/WB forwarding value.
- o_A, o_B  out  XLEN each  ALU operands.
- o_alu_ctrl  out  4  to ALU.
- o_store_data  out  XLEN  forwarded rt for stores.
- o_rd  out  RA_W  destination register.
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1 each  control to EX/MEM.
- o_valid  out  1  EX slot valid.
- o_stall  out  1  load-use stall request to IF/ID.

Behaviour:
- Reset (async, i_rst_n=0): every registered field clears to 0, so o_valid=0, all control outputs 0, o_rd=0, o_alu_ctrl=4'b0000. o_stall=0. o_A, o_B and o_store_data reduce to the forwarding mux result of all-zero register fields.
- Per-edge update priority:
  - i_flush: load bubble (valid=0, all control 0).
  - else i_hold: keep contents.
  - else o_stall: load bubble.
  - else capture all ID inputs.
- Latency: one register stage. o_A, o_B and o_store_data are combinational from the registered fields plus the current forwarding inputs.
- Forward select per source (rs, rt), fields taken from the registered instruction:
  - EX/MEM if i_exmem_reg_write and i_exmem_rd==src and src!=0.
  - else MEM/WB under the same rule.
  - else the registered file data.
  - EX/MEM wins when both stages match.
  - Register 0 is never forwarded.
- Operand mux:
  - r_shift=1: o_A = fwd_rt, o_B = r_imm (the ALU reads shamt from B[10:6]).
  - else: o_A = fwd_rs, o_B = r_alu_src ? r_imm : fwd_rt.
  - o_store_data = fwd_rt always.
- Load-use: o_stall = r_valid & r_mem_read & (r_rd!=0) & i_valid & (i_rs==r_rd | i_rt==r_rd).
  - Comparison is conservative: rt is always compared.
  - o_stall is forced to 0 while i_hold or i_flush is asserted.
- Bubble fields: r_rd=0, r_alu_ctrl=0; the remaining data fields are don't-care but are zeroed.
- Mid-operation reset clears the stage immediately; no partial state survives.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt (32 bits, reset 0).
  - Increments on every edge where o_stall=1 and the stall is taken, i.e. i_hold=0 and i_flush=0.
  - Wraps at 2^32-1 to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - XLEN and RA_W defaults.
  - ALU control constants: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLTU 1000, SLL 1001, SRA 1010, SRL 1011, XOR 1101.
  - Forward-select enum: FWD_RF, FWD_MEMWB, FWD_EXMEM.
- One sub-module, fwd_unit:
  - Combinational; instantiated twice (rs, rt).
  - Returns the select and the forwarded value.

Test Plan:
- Reset mid-stream: assert i_rst_n=0 asynchronously while o_valid=1 -> o_valid, o_reg_write and o_stall drop to 0 before the next edge.
- EX/MEM forwarding: ADD rs=3, rt=4 registered; i_exmem_rd=3, result 0x55, write=1; i_memwb_rd=3, result 0x66 -> o_A=0x55 (EX/MEM priority), o_B=i_rt_data.
- r0 guard: registered rs=0, i_exmem_rd=0, write=1, result 0xDEAD -> o_A = registered rs_data (0), not 0xDEAD.
- Load-use: registered LW rd=5, i_valid=1, i_rt=5 -> o_stall=1; next edge loads a bubble (o_valid=0, o_reg_write=0); the following cycle o_stall=0.
- Shift: i_shift=1, i_imm[10:6]=4, rt data 0x1, alu_ctrl 1001 -> o_A=0x1, o_B[10:6]=4, o_alu_ctrl=1001.
- Flush vs hold: i_flush=1 and i_hold=1 together -> bubble loaded. With ID_EX_STALL_CNT_EN, a held load-use stall does not increment o_stall_cnt.
